// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Edge-detected point scoring with post-point hold and win latch.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       hold,
  output logic       serve_p2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HOLD = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [3:0]  C_WIN  = 4'(WIN_SCORE);
  localparam logic [15:0] C_HOLD = 16'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        p1_prev_q, p2_prev_q, ng_prev_q;
  logic [3:0]  p1_score_q, p2_score_q;
  logic        hold_q, serve_p2_q, game_over_q;
  logic [1:0]  winner_q;

  logic        w_p1_ev, w_p2_ev, w_ng_ev;
  logic [3:0]  p1_score_d, p2_score_d;

  assign w_p1_ev    = p1_point & ~p1_prev_q;
  assign w_p2_ev    = p2_point & ~p2_prev_q;
  assign w_ng_ev    = new_game & ~ng_prev_q;
  assign p1_score_d = p1_score_q + 4'd1;
  assign p2_score_d = p2_score_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_PLAY;
      cnt_q       <= '0;
      p1_prev_q   <= 1'b0;
      p2_prev_q   <= 1'b0;
      ng_prev_q   <= 1'b0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      hold_q      <= 1'b0;
      serve_p2_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      p1_prev_q <= p1_point;
      p2_prev_q <= p2_point;
      ng_prev_q <= new_game;
      if (w_ng_ev) begin
        state_q     <= S_PLAY;
        cnt_q       <= '0;
        p1_score_q  <= '0;
        p2_score_q  <= '0;
        hold_q      <= 1'b0;
        serve_p2_q  <= 1'b0;
        game_over_q <= 1'b0;
        winner_q    <= 2'b00;
      end else begin
        case (state_q)
          S_PLAY: begin
            // Simultaneous point edges cancel each other out.
            if (w_p1_ev && !w_p2_ev) begin
              p1_score_q <= p1_score_d;
              serve_p2_q <= 1'b1;
              if (p1_score_d == C_WIN) begin
                state_q     <= S_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b01;
              end else begin
                state_q <= S_HOLD;
                cnt_q   <= C_HOLD;
                hold_q  <= 1'b1;
              end
            end else if (w_p2_ev && !w_p1_ev) begin
              p2_score_q <= p2_score_d;
              serve_p2_q <= 1'b0;
              if (p2_score_d == C_WIN) begin
                state_q     <= S_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b10;
              end else begin
                state_q <= S_HOLD;
                cnt_q   <= C_HOLD;
                hold_q  <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (cnt_q == 16'd0) begin
              state_q <= S_PLAY;
              hold_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          S_OVER: begin
          end
          default: begin
            state_q <= S_PLAY;
            hold_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign hold      = hold_q;
  assign serve_p2  = serve_p2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Randomized and directed checks of two score_keeper configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int WIN_A = 3, HOLD_A = 4;
  localparam int WIN_B = 9, HOLD_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic p1 = 1'b0, p2 = 1'b0, ng = 1'b0;

  logic [3:0] p1_a, p2_a, p1_b, p2_b;
  logic       hold_a, serve_a, over_a, hold_b, serve_b, over_b;
  logic [1:0] win_a, win_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(WIN_A), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .reset(reset), .p1_point(p1), .p2_point(p2), .new_game(ng),
    .p1_score(p1_a), .p2_score(p2_a), .hold(hold_a), .serve_p2(serve_a),
    .game_over(over_a), .winner(win_a)
  );

  score_keeper #(.WIN_SCORE(WIN_B), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .reset(reset), .p1_point(p1), .p2_point(p2), .new_game(ng),
    .p1_score(p1_b), .p2_score(p2_b), .hold(hold_b), .serve_p2(serve_b),
    .game_over(over_b), .winner(win_b)
  );

  // Reference model: scores as integers, hold as "cycles of hold remaining".
  int m_s1[2], m_s2[2], m_left[2], m_win[2];
  bit m_serve[2], m_over[2];
  bit m_pa, m_pb, m_pn;

  always @(posedge clk or negedge reset) begin
    bit e1, e2, en;
    int w, h;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_left[k] = 0; m_win[k] = 0;
        m_serve[k] = 0; m_over[k] = 0;
      end
      m_pa = 0; m_pb = 0; m_pn = 0;
    end else begin
      e1 = p1 && !m_pa;
      e2 = p2 && !m_pb;
      en = ng && !m_pn;
      for (int k = 0; k < 2; k++) begin
        w = (k == 0) ? WIN_A : WIN_B;
        h = (k == 0) ? HOLD_A : HOLD_B;
        if (en) begin
          m_s1[k] = 0; m_s2[k] = 0; m_left[k] = 0; m_win[k] = 0;
          m_serve[k] = 0; m_over[k] = 0;
        end else if (m_over[k]) begin
        end else if (m_left[k] > 0) begin
          m_left[k]--;
        end else if (e1 != e2) begin
          if (e1) begin m_s1[k]++; m_serve[k] = 1; end
          else    begin m_s2[k]++; m_serve[k] = 0; end
          if (m_s1[k] == w)      begin m_over[k] = 1; m_win[k] = 1; end
          else if (m_s2[k] == w) begin m_over[k] = 1; m_win[k] = 2; end
          else m_left[k] = h;
        end
      end
      m_pa = p1; m_pb = p2; m_pn = ng;
    end
  end

  function automatic logic [12:0] exp_vec(int k);
    return {4'(m_s1[k]), 4'(m_s2[k]), (m_left[k] > 0), m_serve[k], m_over[k], 2'(m_win[k])};
  endfunction

  wire [12:0] obs_a = {p1_a, p2_a, hold_a, serve_a, over_a, win_a};
  wire [12:0] obs_b = {p1_b, p2_b, hold_b, serve_b, over_b, win_b};

  task automatic drive(input logic a, input logic b, input logic n);
    @(negedge clk);
    p1 = a; p2 = b; ng = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; p1 = 0; p2 = 0; ng = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (obs_a !== 13'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", obs_a); end
    n_checks++;
    if (obs_b !== 13'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", obs_b); end
  endtask

  task automatic test_point_hold();
    int highs;
    drive(1, 0, 0);
    n_checks++;
    if ({p1_a, serve_a, hold_a} !== {4'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL point_p1: got p1=%0d serve=%b hold=%b want 1 1 1", p1_a, serve_a, hold_a);
    end
    highs = 1;
    drive(0, 1, 0);
    if (hold_a) highs++;
    n_checks++;
    if (p2_a !== 4'd0) begin n_fail++; $display("FAIL p2_in_hold: got %0d want 0", p2_a); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      if (hold_a) highs++;
      n_checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        n_fail++; $display("FAIL hold_seq: got %h/%h want %h/%h", obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    n_checks++;
    if (highs != HOLD_A) begin n_fail++; $display("FAIL hold_len: got %0d want %0d", highs, HOLD_A); end
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0);
    n_checks++;
    if (obs_a !== exp_vec(0) || hold_a !== 1'b0 || p1_a !== 4'd1 || p2_a !== 4'd0) begin
      n_fail++; $display("FAIL simultaneous: got %h want %h", obs_a, exp_vec(0));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_win();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0);
      n_checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        n_fail++; $display("FAIL win_step%0d: got %h/%h want %h/%h", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (i < 2) repeat (5) drive(0, 0, 0);
    end
    n_checks++;
    if ({p2_a, over_a, win_a, hold_a} !== {4'd3, 1'b1, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL win_over: got p2=%0d over=%b win=%b hold=%b want 3 1 10 0", p2_a, over_a, win_a, hold_a);
    end
    drive(0, 0, 0);
    drive(1, 0, 0);
    n_checks++;
    if (p1_a !== 4'd0 || obs_b !== exp_vec(1)) begin
      n_fail++; $display("FAIL over_ignores: got p1=%0d b=%h want 0 b=%h", p1_a, obs_b, exp_vec(1));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_newgame_over();
    drive(1, 0, 1);
    n_checks++;
    if (obs_a !== 13'd0) begin n_fail++; $display("FAIL newgame_a: got %h want 0", obs_a); end
    n_checks++;
    if (obs_b !== exp_vec(1)) begin n_fail++; $display("FAIL newgame_b: got %h want %h", obs_b, exp_vec(1)); end
    drive(0, 0, 0);
  endtask

  task automatic test_held_high();
    repeat (20) drive(1, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (p1_a !== 4'd1 || p1_b !== 4'd1) begin
      n_fail++; $display("FAIL held_high: got %0d/%0d want 1/1", p1_a, p1_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0);
    repeat (4) drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (p1_a !== 4'd2 || hold_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_async: got p1=%0d hold=%b want 2 1", p1_a, hold_a);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %h/%h want 0/0", obs_a, obs_b);
    end
    @(negedge clk);
    reset = 1'b1; p1 = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (p1_a !== 4'd1 || obs_a !== exp_vec(0)) begin
      n_fail++; $display("FAIL after_release: got %h want %h", obs_a, exp_vec(0));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      n_checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        n_fail++; $display("FAIL random%0d: got %h/%h want %h/%h", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_point_hold();
    test_simultaneous();
    test_win();
    test_newgame_over();
    test_held_high();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
